mem_access_ctrl: RTL and testbench

Load/store sequencer that sits directly upstream of the unified byte-addressed instruction/data memory, between the multicycle datapath and the memory. The memory only performs full-word reads and writes. This block turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. It extracts and extends bytes and halfwords for loads, does read-modify-write for sub-word stores, and flags misaligned or out-of-range accesses.

---
 rtl/mem_access_ctrl_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 62 ++++++
 rtl/mem_access_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: funct3 encodings,
// FSM state encoding and the access-legality rule.
package mem_access_ctrl_pkg;

  // RISC-V load/store width encodings (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Selects the byte offset inside a 32-bit word
  localparam logic [1:0] WORD_OFS_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // True when the width/offset combination cannot be served: misaligned
  // halfword/word, reserved load encodings, or unsigned encodings on a store.
  function automatic logic access_err(input logic       is_store,
                                      input logic [2:0] f3,
                                      input logic [1:0] k);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = k[0];
      F3_W:    bad = (k != 2'b00);
      F3_BU:   bad = is_store;
      F3_HU:   bad = is_store | k[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane logic between a full memory word and the datapath.
// Memory byte order is big-endian within the word: byte offset 0 is the MSB.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] i_word,
  input  logic [1:0]   i_k,
  input  logic [2:0]   i_funct3,
  input  logic [N-1:0] i_wdata,
  output logic [N-1:0] o_load,
  output logic [N-1:0] o_store
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane and extend it to a load result
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_byte = i_word[N-1 -: 8];
    w_half = i_word[N-1 -: 16];
    o_load = '0;
    case (i_k)
      2'd0: w_byte = i_word[N-1  -: 8];
      2'd1: w_byte = i_word[N-9  -: 8];
      2'd2: w_byte = i_word[N-17 -: 8];
      2'd3: w_byte = i_word[N-25 -: 8];
    endcase
    if (i_k[1]) w_half = i_word[N-17 -: 16];
    case (i_funct3)
      F3_B:    o_load = {{(N-8){w_byte[7]}}, w_byte};
      F3_BU:   o_load = {{(N-8){1'b0}}, w_byte};
      F3_H:    o_load = {{(N-16){w_half[15]}}, w_half};
      F3_HU:   o_load = {{(N-16){1'b0}}, w_half};
      F3_W:    o_load = i_word;
      default: o_load = '0;
    endcase
  end

  // Merge store data into the word read back from memory
  always_comb begin
    o_store = i_word;
    case (i_funct3)
      F3_B: begin
        case (i_k)
          2'd0: o_store[N-1  -: 8] = i_wdata[7:0];
          2'd1: o_store[N-9  -: 8] = i_wdata[7:0];
          2'd2: o_store[N-17 -: 8] = i_wdata[7:0];
          2'd3: o_store[N-25 -: 8] = i_wdata[7:0];
        endcase
      end
      F3_H: begin
        if (i_k[1]) o_store[N-17 -: 16] = i_wdata[15:0];
        else        o_store[N-1  -: 16] = i_wdata[15:0];
      end
      default: o_store = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of a word-only memory. Sub-word stores are
// done as read-modify-write; illegal accesses complete with err and no write.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 7
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req,
  input  logic         we,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic         ready,
  output logic         done,
  output logic         err,
  output logic [N-1:0] rdata,
  output logic         mem_we,
  output logic [N-1:0] mem_a,
  output logic [N-1:0] mem_wd,
  input  logic [N-1:0] mem_rd
);

  state_t       r_state;
  state_t       w_next_state;

  logic         r_we;
  logic [2:0]   r_funct3;
  logic [1:0]   r_k;
  logic [N-1:0] r_wdata;
  logic [N-1:0] r_mem_a;
  logic [N-1:0] r_mem_wd;
  logic [N-1:0] r_rdata;
  logic         r_err;

  logic [1:0]   w_k;
  logic [N-1:0] w_word_a;
  logic         w_out_of_range;
  logic         w_reject;
  logic         w_is_sw;
  logic [N-1:0] w_load_val;
  logic [N-1:0] w_store_word;

  assign w_k            = addr[1:0] & WORD_OFS_MASK;
  assign w_word_a       = {addr[N-1:2], 2'b00};
  assign w_out_of_range = |w_word_a[N-1:M];
  assign w_reject       = access_err(we, funct3, w_k) | w_out_of_range;
  assign w_is_sw        = we & (funct3 == F3_W);

  // Lane logic sees the word arriving during READ, so both the load result
  // and the merged store word are ready at the edge that closes READ.
  mem_lane_align #(.N(N)) u_lane (
    .i_word   (mem_rd),
    .i_k      (r_k),
    .i_funct3 (r_funct3),
    .i_wdata  (r_wdata),
    .o_load   (w_load_val),
    .o_store  (w_store_word)
  );

  // State register; reset wins over any request
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req) begin
          if (w_reject)     w_next_state = DONE;
          else if (w_is_sw) w_next_state = WRITE;
          else              w_next_state = READ;
        end
      end
      READ:    w_next_state = r_we ? WRITE : DONE;
      WRITE:   w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decoded from state and registers only
  always_comb begin
    ready  = (r_state == IDLE);
    done   = (r_state == DONE);
    err    = (r_state == DONE) & r_err;
    mem_we = (r_state == WRITE);
    rdata  = r_rdata;
    mem_a  = r_mem_a;
    mem_wd = r_mem_wd;
  end

  // Request latch, read capture and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_k      <= '0;
      r_wdata  <= '0;
      r_mem_a  <= '0;
      r_mem_wd <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_we     <= we;
            r_funct3 <= funct3;
            r_k      <= w_k;
            r_wdata  <= wdata;
            r_mem_a  <= w_word_a;
            r_err    <= w_reject;
            // A full-word store goes straight to WRITE with the raw data
            r_mem_wd <= wdata;
          end
        end
        READ: begin
          if (r_we) r_mem_wd <= w_store_word;
          else      r_rdata  <= w_load_val;
        end
        DONE: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: byte-array memory, a reference
// byte-level model with per-cycle comparison, plus directed literal checks.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready, done, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_ctrl #(.N(32), .M(7)) dut (
    .CLK(CLK), .RST(RST), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 CLK = ~CLK;

  // ---------------- memory: 128 bytes, mem[A] is the word MSB ----------------
  logic [7:0] mem     [0:127];
  logic [7:0] ref_mem [0:127];

  always @(posedge CLK) begin
    if (mem_we === 1'b1) begin
      for (int j = 0; j < 4; j++) mem[int'(mem_a[6:0]) + j] = mem_wd[31-8*j -: 8];
    end
  end

  always @(negedge CLK) begin
    mem_rd = {mem[int'(mem_a[6:0])],     mem[int'(mem_a[6:0]) + 1],
              mem[int'(mem_a[6:0]) + 2], mem[int'(mem_a[6:0]) + 3]};
  end

  function automatic logic [31:0] word_at(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Tracks one operation as (cycles since accept, completion cycle, write
  // cycle) and derives results from byte arithmetic on ref_mem.
  bit          m_busy;
  int          m_c, m_l, m_lw;
  logic        m_err;
  logic [31:0] m_rdata, m_a, m_wd;

  task automatic model_accept();
    int          sz, k, wa;
    logic [31:0] wa_u;
    bit          bad, sgn;
    longint      v;
    logic [7:0]  wb [4];
    k    = int'(addr[1:0]);
    wa_u = addr & 32'hFFFF_FFFC;
    case (funct3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    if (we && funct3 > 3'd2) sz = 0;
    bad = (sz == 0) ? 1'b1 : ((k % sz) != 0);
    if (wa_u >= 32'd128) bad = 1'b1;
    sgn = !we && (funct3 == 3'd0 || funct3 == 3'd1);
    m_busy = 1'b1; m_c = 0; m_err = bad; m_rdata = '0; m_a = wa_u; m_wd = '0;
    if (bad) begin
      m_l = 1; m_lw = -1;
    end else if (!we) begin
      wa = int'(wa_u);
      v = 0;
      for (int i = 0; i < sz; i++) v = v * 256 + longint'(ref_mem[wa + k + i]);
      if (sgn && v >= (longint'(1) << (8*sz - 1))) v = v - (longint'(1) << (8*sz));
      m_rdata = v[31:0];
      m_l = 2; m_lw = -1;
    end else begin
      wa = int'(wa_u);
      for (int j = 0; j < 4; j++) wb[j] = ref_mem[wa + j];
      for (int i = 0; i < sz; i++) wb[k + i] = 8'((wdata >> (8*(sz-1-i))) & 32'hFF);
      m_wd = {wb[0], wb[1], wb[2], wb[3]};
      m_l  = (sz == 4) ? 2 : 3;
      m_lw = m_l - 1;
    end
  endtask

  // Compare process: every cycle after the first reset edge
  initial begin
    logic        e_ready, e_done, e_err, e_we;
    logic [99:0] m_exp, m_act;
    m_busy = 1'b0; m_c = 0; m_l = 0; m_lw = -1;
    m_err = 1'b0; m_rdata = '0; m_a = '0; m_wd = '0;
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      if (!m_busy && req && !RST) model_accept();
      e_ready = !m_busy || (m_c == 0);
      e_done  = m_busy && (m_c == m_l);
      e_err   = e_done && m_err;
      e_we    = m_busy && (m_c == m_lw);
      m_exp = {e_ready, e_done, e_err, e_we, (e_done ? m_rdata : 32'h0),
               (e_we ? m_a : 32'h0), (e_we ? m_wd : 32'h0)};
      m_act = {ready, done, err, mem_we, rdata,
               (e_we ? mem_a : 32'h0), (e_we ? mem_wd : 32'h0)};
      check($sformatf("cycle@%0t", $time), 128'(m_act), 128'(m_exp));
      if (m_busy) begin
        if (m_c == m_lw)
          for (int j = 0; j < 4; j++) ref_mem[int'(m_a[6:0]) + j] = m_wd[31-8*j -: 8];
        m_c++;
        if (m_c > m_l) m_busy = 1'b0;
      end
      if (RST) m_busy = 1'b0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input logic w, input logic [2:0] f, input logic [31:0] a, d,
                        output logic [31:0] rd, output logic e, output int lat);
    @(posedge CLK); #1;
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    @(posedge CLK); #1;
    req = 1'b0;
    lat = -1; rd = '0; e = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        lat = n; rd = rdata; e = err;
        break;
      end
    end
  endtask

  task automatic expect_op(input string name, input logic w, input logic [2:0] f,
                           input logic [31:0] a, d, exp_rd, input logic exp_e,
                           input int exp_lat);
    logic [31:0] rd;
    logic        e;
    int          lat;
    run_op(w, f, a, d, rd, e, lat);
    check(name, 128'({rd, e, 8'(lat)}), 128'({exp_rd, exp_e, 8'(exp_lat)}));
  endtask

  initial begin
    int dn, c1, c2, diffs;
    RST = 1'b1; req = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 128; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[16] = 8'h88; mem[17] = 8'h99; mem[18] = 8'hAA; mem[19] = 8'hBB;
    mem[20] = 8'h01; mem[21] = 8'h02; mem[22] = 8'h03; mem[23] = 8'h04;
    mem[124] = 8'hDE; mem[125] = 8'hAD; mem[126] = 8'hBE; mem[127] = 8'hEF;
    for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("reset_state", 128'({ready, done, err, mem_we, rdata, mem_a, mem_wd}),
          128'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0}));

    // Loads: width, extension, latency 2
    expect_op("lw_10",  1'b0, F3_W,  32'h10, 32'h0, 32'h8899AABB, 1'b0, 2);
    expect_op("lb_11",  1'b0, F3_B,  32'h11, 32'h0, 32'hFFFFFF99, 1'b0, 2);
    expect_op("lbu_11", 1'b0, F3_BU, 32'h11, 32'h0, 32'h00000099, 1'b0, 2);
    expect_op("lh_12",  1'b0, F3_H,  32'h12, 32'h0, 32'hFFFFAABB, 1'b0, 2);
    expect_op("lhu_12", 1'b0, F3_HU, 32'h12, 32'h0, 32'h0000AABB, 1'b0, 2);
    expect_op("lw_7c",  1'b0, F3_W,  32'h7C, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Sub-word stores: read-modify-write, latency 3
    expect_op("sb_13", 1'b1, F3_B, 32'h13, 32'h12345677, 32'h0, 1'b0, 3);
    check("mem10_after_sb", 128'(word_at(16)), 128'(32'h8899AA77));
    expect_op("sh_10", 1'b1, F3_H, 32'h10, 32'h0000CAFE, 32'h0, 1'b0, 3);
    expect_op("lw_10_rb", 1'b0, F3_W, 32'h10, 32'h0, 32'hCAFEAA77, 1'b0, 2);

    // Full-word store, latency 2
    expect_op("sw_18", 1'b1, F3_W, 32'h18, 32'h01020304, 32'h0, 1'b0, 2);
    expect_op("lw_18", 1'b0, F3_W, 32'h18, 32'h0, 32'h01020304, 1'b0, 2);

    // Rejected accesses: err in cycle 1, no write
    expect_op("sh_11_err",  1'b1, F3_H,   32'h11, 32'hFFFF, 32'h0, 1'b1, 1);
    expect_op("lw_12_err",  1'b0, F3_W,   32'h12, 32'h0,    32'h0, 1'b1, 1);
    expect_op("lw_80_err",  1'b0, F3_W,   32'h80, 32'h0,    32'h0, 1'b1, 1);
    expect_op("ld_011_err", 1'b0, 3'b011, 32'h10, 32'h0,    32'h0, 1'b1, 1);
    expect_op("st_100_err", 1'b1, 3'b100, 32'h10, 32'hAB,   32'h0, 1'b1, 1);
    check("mem10_after_err", 128'(word_at(16)), 128'(32'hCAFEAA77));

    // Reset in the READ cycle of an SB aborts it
    @(posedge CLK); #1;
    req = 1'b1; we = 1'b1; funct3 = F3_B; addr = 32'h10; wdata = 32'h55;
    @(posedge CLK); #1;
    req = 1'b0; RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_abort", 128'({ready, done, err, mem_we, rdata, mem_a, mem_wd}),
          128'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0}));
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (done === 1'b1 || mem_we === 1'b1) dn++;
    end
    check("rst_no_activity", 128'(dn), 128'(0));
    check("mem10_after_rst", 128'(word_at(16)), 128'(32'hCAFEAA77));
    expect_op("lw_10_post_rst", 1'b0, F3_W, 32'h10, 32'h0, 32'hCAFEAA77, 1'b0, 2);

    // req held high: second SB taken only in the IDLE cycle after DONE
    @(posedge CLK); #1;
    req = 1'b1; we = 1'b1; funct3 = F3_B; addr = 32'h14; wdata = 32'h11;
    @(posedge CLK); #1;
    wdata = 32'h22;
    dn = 0; c1 = -1; c2 = -1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        dn++;
        if (c1 < 0) c1 = c; else c2 = c;
      end
      @(posedge CLK); #1;
      if (c == 4) req = 1'b0;
    end
    check("hold_req_dones", 128'({8'(dn), 8'(c1), 8'(c2)}), 128'({8'd2, 8'd3, 8'd7}));
    check("mem14_after_hold", 128'(word_at(20)), 128'(32'h22020304));

    // Whole memory image against the reference model
    @(negedge CLK);
    diffs = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image", 128'(diffs), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
